// File: rtl/nand_addr_cmd_capture.sv
// Device-side capture of the NAND-style command/address bus: synchronizes the raw
// lines, latches bytes on WE rising edges, reports commands and hands assembled addresses downstream.
module nand_addr_cmd_capture #(
    parameter int ADDR_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_n,
    input  logic                     cle,
    input  logic                     ale,
    input  logic                     we_n,
    input  logic [7:0]               iox,
    output logic                     cmd_valid,
    output logic [7:0]               cmd,
    output logic                     addr_valid,
    output logic [8*ADDR_CYCLES-1:0] addr,
    input  logic                     addr_ready,
    output logic                     proto_err,
    output logic                     overflow,
    output logic [1:0]               dbg_state
);

    localparam int CW = $clog2(ADDR_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(ADDR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    // Handshake: addr is transferred on any clk edge where addr_valid && addr_ready;
    // addr_valid never drops and addr never changes until that transfer happens.

    logic [SYNC_STAGES-1:0] ce_sync_q, cle_sync_q, ale_sync_q, we_sync_q;
    logic [7:0]             io_sync_q [SYNC_STAGES];
    logic                   we_prev_q;

    // Synchronizers reset to the idle bus so reset release cannot fake a WE edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_sync_q  <= '1;
            cle_sync_q <= '0;
            ale_sync_q <= '0;
            we_sync_q  <= '1;
            we_prev_q  <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) io_sync_q[i] <= '0;
        end else begin
            ce_sync_q  <= {ce_sync_q[SYNC_STAGES-2:0], ce_n};
            cle_sync_q <= {cle_sync_q[SYNC_STAGES-2:0], cle};
            ale_sync_q <= {ale_sync_q[SYNC_STAGES-2:0], ale};
            we_sync_q  <= {we_sync_q[SYNC_STAGES-2:0], we_n};
            we_prev_q  <= we_sync_q[SYNC_STAGES-1];
            io_sync_q[0] <= iox;
            for (int i = 1; i < SYNC_STAGES; i++) io_sync_q[i] <= io_sync_q[i-1];
        end
    end

    logic       ce_s, cle_s, ale_s, we_s, latch;
    logic       is_cmd, is_addr, is_bad;
    logic [7:0] io_s;

    assign ce_s    = ce_sync_q[SYNC_STAGES-1];
    assign cle_s   = cle_sync_q[SYNC_STAGES-1];
    assign ale_s   = ale_sync_q[SYNC_STAGES-1];
    assign we_s    = we_sync_q[SYNC_STAGES-1];
    assign io_s    = io_sync_q[SYNC_STAGES-1];
    assign latch   = we_s & ~we_prev_q & ~ce_s;
    assign is_cmd  = latch & cle_s & ~ale_s;
    assign is_addr = latch & ~cle_s & ale_s;
    assign is_bad  = latch & cle_s & ale_s;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [8*ADDR_CYCLES-1:0] addr_q, addr_d;
    logic [7:0]               cmd_q, cmd_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic                     proto_err_q, proto_err_d;
    logic                     overflow_q, overflow_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            proto_err_q <= proto_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        cmd_d       = is_cmd ? io_s : cmd_q;
        cmd_valid_d = is_cmd;
        proto_err_d = is_bad;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (is_addr) begin
                    addr_d[7:0] = io_s;
                    if (ADDR_CYCLES == 1) begin
                        state_d = S_HOLD;
                        count_d = '0;
                    end else begin
                        state_d = S_COLLECT;
                        count_d = CW'(1);
                    end
                end
            end
            S_COLLECT: begin
                if (is_addr) begin
                    for (int i = 0; i < ADDR_CYCLES; i++) begin
                        if (count_q == CW'(i)) addr_d[8*i +: 8] = io_s;
                    end
                    if (count_q == LAST) begin
                        state_d = S_HOLD;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (is_cmd) begin
                    proto_err_d = 1'b1;
                    state_d     = S_IDLE;
                    count_d     = '0;
                end
                // Byte handling above runs first; a deselected chip then aborts the phase.
                if (ce_s && state_d == S_COLLECT) begin
                    proto_err_d = 1'b1;
                    state_d     = S_IDLE;
                    count_d     = '0;
                end
            end
            S_HOLD: begin
                if (is_addr) overflow_d = 1'b1;
                if (addr_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd        = cmd_q;
    assign addr_valid = (state_q == S_HOLD);
    assign addr       = addr_q;
    assign proto_err  = proto_err_q;
    assign overflow   = overflow_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_nand_addr_cmd_capture.sv
// Directed bench for nand_addr_cmd_capture: bus-cycle driver task, output-pulse
// monitor, one task per scenario with hand-computed expectations.
module tb_nand_addr_cmd_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_n = 1'b1, cle = 1'b0, ale = 1'b0, we_n = 1'b1;
    logic [7:0]  iox = 8'h00;
    logic        addr_ready = 1'b0;
    logic        cmd_valid, addr_valid, proto_err, overflow;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  dbg_state;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    nand_addr_cmd_capture #(.ADDR_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ce_n(ce_n), .cle(cle), .ale(ale), .we_n(we_n),
        .iox(iox), .cmd_valid(cmd_valid), .cmd(cmd), .addr_valid(addr_valid),
        .addr(addr), .addr_ready(addr_ready), .proto_err(proto_err),
        .overflow(overflow), .dbg_state(dbg_state)
    );

    // Pulse monitor, sampled 1 time unit after each rising edge.
    int         cmd_cnt = 0, perr_cnt = 0, av_rise = 0;
    logic [7:0] last_cmd = 8'h00;
    logic       av_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cmd_valid === 1'b1) begin
            cmd_cnt++;
            last_cmd = cmd;
        end
        if (proto_err === 1'b1) perr_cnt++;
        if (addr_valid === 1'b1 && av_prev !== 1'b1) av_rise++;
        av_prev = addr_valid;
    end

    int c0, p0, a0;
    task automatic snap();
        c0 = cmd_cnt;
        p0 = perr_cnt;
        a0 = av_rise;
    endtask

    // Outputs seen 2 and 3 rising edges after WE goes high on the raw bus.
    logic v2_cmd, v3_cmd, v2_av, v3_av;

    task automatic bus_byte(input logic c, input logic a, input logic [7:0] d);
        @(negedge clk);
        cle = c; ale = a; iox = d; we_n = 1'b0;
        repeat (3) @(negedge clk);
        we_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        v2_cmd = cmd_valid; v2_av = addr_valid;
        @(posedge clk); #1;
        v3_cmd = cmd_valid; v3_av = addr_valid;
        repeat (2) @(negedge clk);
        cle = 1'b0; ale = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic accept();
        @(negedge clk); addr_ready = 1'b1;
        @(negedge clk); addr_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cmd_valid, addr_valid, proto_err, overflow} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=0000", {cmd_valid, addr_valid, proto_err, overflow});
        end
        checks++;
        if (cmd !== 8'h00 || addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_data cmd=%h addr=%h exp 00/00000000", cmd, addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ce_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cmd_addr();
        snap();
        bus_byte(1'b1, 1'b0, 8'h80);
        checks++;
        if (v2_cmd !== 1'b0 || v3_cmd !== 1'b1) begin
            fails++;
            $display("FAIL cmd_latency edge2=%b edge3=%b exp 0/1", v2_cmd, v3_cmd);
        end
        bus_byte(1'b0, 1'b1, 8'h11);
        bus_byte(1'b0, 1'b1, 8'h22);
        bus_byte(1'b0, 1'b1, 8'h33);
        bus_byte(1'b0, 1'b1, 8'h44);
        checks++;
        if (v2_av !== 1'b0 || v3_av !== 1'b1) begin
            fails++;
            $display("FAIL addr_latency edge2=%b edge3=%b exp 0/1", v2_av, v3_av);
        end
        checks++;
        if (cmd_cnt - c0 != 1 || last_cmd !== 8'h80) begin
            fails++;
            $display("FAIL cmd_capture count=%0d cmd=%h exp 1/80", cmd_cnt - c0, last_cmd);
        end
        checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h44332211) begin
            fails++;
            $display("FAIL addr_assembly valid=%b addr=%h exp 1/44332211", addr_valid, addr);
        end
        checks++;
        if (perr_cnt != p0) begin
            fails++;
            $display("FAIL cmd_addr_no_err proto_err pulses=%0d exp 0", perr_cnt - p0);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (addr_valid !== 1'b1 || addr !== 32'h44332211) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable unstable_cycles=%0d exp 0 (addr=%h)", bad, addr);
        end
        @(negedge clk); addr_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (addr_valid !== 1'b0) begin
            fails++;
            $display("FAIL accept_drop addr_valid=%b exp 0", addr_valid);
        end
        @(negedge clk); addr_ready = 1'b0;
    endtask

    task automatic test_abort();
        snap();
        bus_byte(1'b0, 1'b1, 8'hAA);
        bus_byte(1'b0, 1'b1, 8'hBB);
        @(negedge clk); ce_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (perr_cnt - p0 != 1 || av_rise != a0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL ce_abort perr=%0d av_rises=%0d state=%0d exp 1/0/0",
                     perr_cnt - p0, av_rise - a0, dbg_state);
        end
        ce_n = 1'b0;
        repeat (3) @(negedge clk);
        bus_byte(1'b0, 1'b1, 8'h01);
        bus_byte(1'b0, 1'b1, 8'h02);
        bus_byte(1'b0, 1'b1, 8'h03);
        bus_byte(1'b0, 1'b1, 8'h04);
        checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h04030201) begin
            fails++;
            $display("FAIL after_abort valid=%b addr=%h exp 1/04030201", addr_valid, addr);
        end
        accept();
    endtask

    task automatic test_cmd_mid_addr();
        snap();
        bus_byte(1'b0, 1'b1, 8'h10);
        bus_byte(1'b0, 1'b1, 8'h20);
        bus_byte(1'b1, 1'b0, 8'h70);
        repeat (3) @(negedge clk);
        checks++;
        if (perr_cnt - p0 != 1 || cmd_cnt - c0 != 1 || last_cmd !== 8'h70) begin
            fails++;
            $display("FAIL cmd_mid_addr perr=%0d cmds=%0d cmd=%h exp 1/1/70",
                     perr_cnt - p0, cmd_cnt - c0, last_cmd);
        end
        checks++;
        if (av_rise != a0 || addr_valid !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL cmd_mid_addr_state av_rises=%0d valid=%b state=%0d exp 0/0/0",
                     av_rise - a0, addr_valid, dbg_state);
        end
    endtask

    task automatic test_overflow();
        bus_byte(1'b0, 1'b1, 8'hA1);
        bus_byte(1'b0, 1'b1, 8'hA2);
        bus_byte(1'b0, 1'b1, 8'hA3);
        bus_byte(1'b0, 1'b1, 8'hA4);
        checks++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_before got=%b exp 0", overflow);
        end
        bus_byte(1'b0, 1'b1, 8'h55);
        checks++;
        if (overflow !== 1'b1 || addr_valid !== 1'b1 || addr !== 32'hA4A3A2A1) begin
            fails++;
            $display("FAIL overflow_set ovf=%b valid=%b addr=%h exp 1/1/a4a3a2a1",
                     overflow, addr_valid, addr);
        end
        accept();
        repeat (2) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || addr_valid !== 1'b0) begin
            fails++;
            $display("FAIL overflow_sticky ovf=%b valid=%b exp 1/0", overflow, addr_valid);
        end
    endtask

    task automatic test_bad_cycle();
        snap();
        bus_byte(1'b1, 1'b1, 8'h99);
        checks++;
        if (perr_cnt - p0 != 1 || cmd_cnt != c0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL cle_ale_both perr=%0d cmds=%0d state=%0d exp 1/0/0",
                     perr_cnt - p0, cmd_cnt - c0, dbg_state);
        end
    endtask

    task automatic test_reset_mid_phase();
        bus_byte(1'b0, 1'b1, 8'h01);
        bus_byte(1'b0, 1'b1, 8'h02);
        bus_byte(1'b0, 1'b1, 8'h03);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, addr_valid, proto_err, overflow} !== 4'b0000 || cmd !== 8'h00 ||
            addr !== 32'h0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid flags=%b cmd=%h addr=%h state=%0d exp 0000/00/00000000/0",
                     {cmd_valid, addr_valid, proto_err, overflow}, cmd, addr, dbg_state);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        snap();
        repeat (6) @(negedge clk);
        checks++;
        if (cmd_cnt != c0 || perr_cnt != p0 || av_rise != a0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_release cmds=%0d perr=%0d av_rises=%0d state=%0d exp 0/0/0/0",
                     cmd_cnt - c0, perr_cnt - p0, av_rise - a0, dbg_state);
        end
        bus_byte(1'b0, 1'b1, 8'h0A);
        bus_byte(1'b0, 1'b1, 8'h0B);
        bus_byte(1'b0, 1'b1, 8'h0C);
        bus_byte(1'b0, 1'b1, 8'h0D);
        checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h0D0C0B0A) begin
            fails++;
            $display("FAIL post_reset_addr valid=%b addr=%h exp 1/0d0c0b0a", addr_valid, addr);
        end
        accept();
    endtask

    initial begin
        test_reset();
        test_cmd_addr();
        test_backpressure();
        test_abort();
        test_cmd_mid_addr();
        test_overflow();
        test_bad_cycle();
        test_reset_mid_phase();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
